pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Central pipeline controller for the five-stage yadan core. It merges stall requests from the ID, EX and MEM stages and a debug halt into the 5-bit stall vector that gates pc, if_id, id_ex, ex_mem and mem_wb. It sequences flushes for branches/jumps and traps, and converts over-long MEM bus waits into a bus-timeout trap. It also keeps a stall-cycle performance counter.

## Interface
- TIMEOUT_CYC, 255: consecutive MEM-stall cycles that trigger a bus timeout; legal range 2..65535.
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- halt_req_i  in  1  debug halt; freezes the whole pipeline
- stallreq_id_i  in  1  ID stall request (load-use hazard)
- stallreq_ex_i  in  1  EX stall request (multi-cycle mul/div)
- stallreq_mem_i  in  1  MEM stall request (bus wait)
- jump_req_i  in  1  EX redirect request
- jump_addr_i  in  32  EX redirect target
- trap_req_i  in  1  MEM exception/interrupt entry request
- trap_vec_i  in  32  trap handler address (mtvec)
- stalled_o  out  5  stall vector: bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb; 1 = hold
- flush_o  out  1  kill if_id and id_ex contents, load new_pc_o into pc
- new_pc_o  out  32  redirect target, valid while flush_o=1
- bus_err_o  out  1  one-cycle pulse on bus timeout
- stall_cycles_o  out  32  saturating count of cycles with stalled_o[0]=1

## Operation
- Bubble rule for pipeline registers: a register inserts a bubble when its own stall bit is 0 and the stall bit of the register before it is 1.
- FSM states: RUN and TRAP_FLUSH. Reset state is RUN.
- In RUN, the first matching rule below applies (decreasing priority):
  - halt_req_i: stalled_o=11111, flush_o=0.
  - Timeout hit: bus_err_o=1, stalled_o=01111, latch trap_vec_i, go to TRAP_FLUSH.
  - stallreq_mem_i: stalled_o=01111 (mem_wb receives a bubble).
  - trap_req_i: stalled_o=00000, latch trap_vec_i, go to TRAP_FLUSH.
  - stallreq_ex_i: stalled_o=00111. A concurrent jump is deferred; EX holds, so the request persists.
  - jump_req_i: stalled_o=00000, flush_o=1, new_pc_o=jump_addr_i, combinationally in the same cycle.
  - stallreq_id_i: stalled_o=00011.
  - None of the above: stalled_o=00000.
- TRAP_FLUSH lasts one cycle: flush_o=1, new_pc_o=latched vector, stalled_o=00000, then return to RUN. If halt_req_i is high in this cycle, the flush still completes, and the halt takes effect in the next cycle.
- Timeout counter (16 bits): increments in RUN each cycle stallreq_mem_i=1 and halt_req_i=0.
  - Clears when stallreq_mem_i=0 or on entering TRAP_FLUSH.
  - Holds its value during a halt.
  - "Timeout hit" means counter == TIMEOUT_CYC-1 with stallreq_mem_i still 1.
- stall_cycles_o increments each cycle stalled_o[0]=1 and saturates at 0xFFFF_FFFF.

## Timing
- stalled_o and the jump-path flush_o/new_pc_o are combinational from the inputs and FSM state; they take effect at the next clk edge.
- Trap redirect latency: trap accepted in cycle N gives flush_o=1 in cycle N+1.
- Timeout: stallreq_mem_i continuously 1 starting at cycle 0 gives bus_err_o=1 in cycle TIMEOUT_CYC-1 and flush_o in cycle TIMEOUT_CYC.
- Reset values: state RUN, timeout counter 0, latched vector 0, stall_cycles_o 0. While rst_n=0: stalled_o=00000, flush_o=0, new_pc_o=0, bus_err_o=0, regardless of inputs.
- Reset asserted mid-TRAP_FLUSH or mid-timeout: all state clears immediately; no flush or bus error follows deassertion.
- Outside flush cycles, new_pc_o=0.

## Test plan
- stallreq_id_i=1 for 2 cycles -> stalled_o=00011 for both cycles, then 00000; stall_cycles_o=2.
- stallreq_ex_i=1 with jump_req_i=1, jump_addr_i=0x100 -> stalled_o=00111, flush_o=0. Next cycle, ex released -> flush_o=1, new_pc_o=0x100.
- trap_req_i=1, trap_vec_i=0x8000_0040 in cycle N -> cycle N+1: flush_o=1, new_pc_o=0x8000_0040, stalled_o=00000; cycle N+2: flush_o=0.
- TIMEOUT_CYC=4, stallreq_mem_i held high -> stalled_o=01111 in cycles 0-3, bus_err_o pulses in cycle 3, flush_o=1 in cycle 4.
- halt_req_i=1 together with stallreq_mem_i and trap_req_i -> stalled_o=11111, timeout counter frozen, no trap taken. On release -> mem stall resumes, then the trap is taken once the mem stall clears.
- rst_n pulled low while in TRAP_FLUSH -> all outputs 0 immediately; after release, stalled_o=00000 and flush_o=0 with idle inputs.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stall requests into the per-stage hold vector,
// sequences jump/trap flushes and turns over-long MEM waits into a bus-error trap.
module pipe_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        jump_req_i,
  input  logic [31:0] jump_addr_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i,
  output logic [4:0]  stalled_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        bus_err_o,
  output logic [31:0] stall_cycles_o
);

  typedef enum logic {
    S_RUN        = 1'b0,
    S_TRAP_FLUSH = 1'b1
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  // Stall vector encodings, bit0 = pc ... bit4 = mem_wb.
  localparam logic [4:0] STALL_ALL = 5'b11111;
  localparam logic [4:0] STALL_MEM = 5'b01111;
  localparam logic [4:0] STALL_EX  = 5'b00111;
  localparam logic [4:0] STALL_ID  = 5'b00011;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_to_cnt;
  logic [15:0] w_to_cnt_nxt;
  logic [31:0] r_trap_vec;
  logic [31:0] w_trap_vec_nxt;
  logic [31:0] r_stall_cyc;

  logic [4:0]  w_stalled;
  logic        w_flush;
  logic [31:0] w_new_pc;
  logic        w_bus_err;
  logic        w_to_hit;

  assign w_to_hit = stallreq_mem_i && (r_to_cnt == TO_LAST);

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt    = r_state;
    w_to_cnt_nxt   = r_to_cnt;
    w_trap_vec_nxt = r_trap_vec;
    w_stalled      = '0;
    w_flush        = 1'b0;
    w_new_pc       = '0;
    w_bus_err      = 1'b0;

    unique case (r_state)
      S_RUN: begin
        if (halt_req_i) begin
          w_stalled = STALL_ALL;
        end else if (w_to_hit) begin
          w_bus_err      = 1'b1;
          w_stalled      = STALL_MEM;
          w_trap_vec_nxt = trap_vec_i;
          w_to_cnt_nxt   = '0;
          w_state_nxt    = S_TRAP_FLUSH;
        end else if (stallreq_mem_i) begin
          w_stalled    = STALL_MEM;
          w_to_cnt_nxt = r_to_cnt + 16'd1;
        end else begin
          w_to_cnt_nxt = '0;
          if (trap_req_i) begin
            w_trap_vec_nxt = trap_vec_i;
            w_state_nxt    = S_TRAP_FLUSH;
          end else if (stallreq_ex_i) begin
            // A pending jump waits: EX is held, so its request is re-presented.
            w_stalled = STALL_EX;
          end else if (jump_req_i) begin
            w_flush  = 1'b1;
            w_new_pc = jump_addr_i;
          end else if (stallreq_id_i) begin
            w_stalled = STALL_ID;
          end
        end
      end
      S_TRAP_FLUSH: begin
        // The flush always completes; a halt raised now is honoured next cycle.
        w_flush      = 1'b1;
        w_new_pc     = r_trap_vec;
        w_to_cnt_nxt = '0;
        w_state_nxt  = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_RUN;
      r_to_cnt   <= '0;
      r_trap_vec <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_to_cnt   <= w_to_cnt_nxt;
      r_trap_vec <= w_trap_vec_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cyc <= '0;
    end else if (stalled_o[0] && (r_stall_cyc != 32'hFFFF_FFFF)) begin
      r_stall_cyc <= r_stall_cyc + 32'd1;
    end
  end

  // NOTE: the combinational outputs are masked by rst_n so that nothing
  // escapes while reset is held, whatever the other inputs are doing.
  assign stalled_o      = rst_n ? w_stalled : '0;
  assign flush_o        = rst_n & w_flush;
  assign new_pc_o       = rst_n ? w_new_pc : '0;
  assign bus_err_o      = rst_n & w_bus_err;
  assign stall_cycles_o = r_stall_cyc;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with a short bus timeout (TIMEOUT_CYC=4).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt_req_i;
  logic        stallreq_id_i;
  logic        stallreq_ex_i;
  logic        stallreq_mem_i;
  logic        jump_req_i;
  logic [31:0] jump_addr_i;
  logic        trap_req_i;
  logic [31:0] trap_vec_i;
  logic [4:0]  stalled_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        bus_err_o;
  logic [31:0] stall_cycles_o;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.TIMEOUT_CYC(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt_req_i     (halt_req_i),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .jump_req_i     (jump_req_i),
    .jump_addr_i    (jump_addr_i),
    .trap_req_i     (trap_req_i),
    .trap_vec_i     (trap_vec_i),
    .stalled_o      (stalled_o),
    .flush_o        (flush_o),
    .new_pc_o       (new_pc_o),
    .bus_err_o      (bus_err_o),
    .stall_cycles_o (stall_cycles_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    halt_req_i     = 1'b0;
    stallreq_id_i  = 1'b0;
    stallreq_ex_i  = 1'b0;
    stallreq_mem_i = 1'b0;
    jump_req_i     = 1'b0;
    jump_addr_i    = '0;
    trap_req_i     = 1'b0;
    trap_vec_i     = '0;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [4:0] st, input logic fl,
                            input logic [31:0] pc, input logic be);
    check({tag, ".stalled"}, 32'(stalled_o), 32'(st));
    check({tag, ".flush"},   32'(flush_o),   32'(fl));
    check({tag, ".new_pc"},  new_pc_o,       pc);
    check({tag, ".bus_err"}, 32'(bus_err_o), 32'(be));
  endtask

  initial begin
    // Reset held with busy inputs: every output must stay quiet.
    rst_n          = 1'b0;
    idle();
    stallreq_id_i  = 1'b1;
    stallreq_mem_i = 1'b1;
    jump_req_i     = 1'b1;
    jump_addr_i    = 32'hDEAD_BEEF;
    halt_req_i     = 1'b1;
    @(negedge clk);
    check_outs("reset", 5'b00000, 1'b0, 32'h0, 1'b0);
    check("reset.stall_cycles", stall_cycles_o, 32'd0);

    next_cycle();
    rst_n = 1'b1;
    idle();
    @(negedge clk);
    check_outs("idle", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Load-use stall for two cycles.
    next_cycle();
    stallreq_id_i = 1'b1;
    @(negedge clk);
    check_outs("id_stall0", 5'b00011, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("id_stall1", 5'b00011, 1'b0, 32'h0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check_outs("id_release", 5'b00000, 1'b0, 32'h0, 1'b0);
    check("id.stall_cycles", stall_cycles_o, 32'd2);

    // EX stall defers a concurrent jump until EX releases.
    next_cycle();
    stallreq_ex_i = 1'b1;
    jump_req_i    = 1'b1;
    jump_addr_i   = 32'h0000_0100;
    @(negedge clk);
    check_outs("ex_hold_jump", 5'b00111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    stallreq_ex_i = 1'b0;
    @(negedge clk);
    check_outs("jump", 5'b00000, 1'b1, 32'h0000_0100, 1'b0);
    check("jump.stall_cycles", stall_cycles_o, 32'd3);

    // Trap: accepted in N, flush in N+1, quiet in N+2.
    next_cycle();
    idle();
    trap_req_i = 1'b1;
    trap_vec_i = 32'h8000_0040;
    @(negedge clk);
    check_outs("trap_accept", 5'b00000, 1'b0, 32'h0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check_outs("trap_flush", 5'b00000, 1'b1, 32'h8000_0040, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("trap_done", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Bus timeout: MEM stall cycles 0..3, bus error in cycle 3, flush in cycle 4.
    next_cycle();
    stallreq_mem_i = 1'b1;
    trap_vec_i     = 32'h0000_0200;
    @(negedge clk);
    check_outs("to_c0", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("to_c1", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("to_c2", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("to_c3", 5'b01111, 1'b0, 32'h0, 1'b1);
    next_cycle();
    trap_vec_i = 32'h0000_0300;
    @(negedge clk);
    check_outs("to_c4", 5'b00000, 1'b1, 32'h0000_0200, 1'b0);
    check("to.stall_cycles", stall_cycles_o, 32'd7);
    next_cycle();
    idle();
    @(negedge clk);
    check_outs("to_after", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Halt over a MEM stall and a trap: counter freezes, trap waits for MEM.
    next_cycle();
    stallreq_mem_i = 1'b1;
    @(negedge clk);
    check_outs("pre_halt_mem", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    halt_req_i = 1'b1;
    trap_req_i = 1'b1;
    trap_vec_i = 32'h8000_0080;
    @(negedge clk);
    check_outs("halt0", 5'b11111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("halt1", 5'b11111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    halt_req_i = 1'b0;
    @(negedge clk);
    check_outs("unhalt_mem0", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("unhalt_mem1", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    stallreq_mem_i = 1'b0;
    @(negedge clk);
    check_outs("late_trap_accept", 5'b00000, 1'b0, 32'h0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check_outs("late_trap_flush", 5'b00000, 1'b1, 32'h8000_0080, 1'b0);
    check("halt.stall_cycles", stall_cycles_o, 32'd12);

    // Reset pulled in the middle of a trap flush.
    next_cycle();
    trap_req_i = 1'b1;
    trap_vec_i = 32'h0000_1234;
    next_cycle();
    idle();
    @(negedge clk);
    check_outs("rst_trap_pre", 5'b00000, 1'b1, 32'h0000_1234, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("rst_trap_now", 5'b00000, 1'b0, 32'h0, 1'b0);
    check("rst_trap.stall_cycles", stall_cycles_o, 32'd0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("rst_trap_after", 5'b00000, 1'b0, 32'h0, 1'b0);

    // Reset pulled in the middle of a timeout count: the count restarts.
    next_cycle();
    stallreq_mem_i = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_outs("rst_to_pre", 5'b01111, 1'b0, 32'h0, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    check_outs("rst_to_now", 5'b00000, 1'b0, 32'h0, 1'b0);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check_outs("rst_to_c0", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("rst_to_c1", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    @(negedge clk);
    check_outs("rst_to_c2", 5'b01111, 1'b0, 32'h0, 1'b0);
    next_cycle();
    idle();
    @(negedge clk);
    check_outs("rst_to_end", 5'b00000, 1'b0, 32'h0, 1'b0);
    check("rst_to.stall_cycles", stall_cycles_o, 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
